// File: rtl/usb2_ulpi_pkg.sv
// usb2_ulpi_pkg: ULPI TX_CMD op codes, extended-address escape and register-port FSM encoding
package usb2_ulpi_pkg;
  localparam logic [1:0] REGWR = 2'b10;
  localparam logic [1:0] REGRD = 2'b11;
  localparam logic [5:0] EXT_ADDR = 6'h2F;
  typedef enum logic [3:0] {IDLE, ARB, CMD, EADDR, WDATA, STP, TURN, RDATA, WAITDIR, DONE} state_t;
  function automatic logic is_ext(input logic [7:0] addr);
    return addr >= {2'b00, EXT_ADDR};
  endfunction
  function automatic logic [7:0] cmd_byte(input logic wr, input logic [7:0] addr);
    return {wr ? REGWR : REGRD, is_ext(addr) ? EXT_ADDR : addr[5:0]};
  endfunction
endpackage

// File: rtl/usb2_ulpi_regport_if.sv
// usb2_ulpi_regport_if: request push and completion signals of the register port
interface usb2_ulpi_regport_if;
  logic req_valid, req_ready, req_wr;
  logic [7:0] req_addr, req_wdata;
  logic rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  modport master(output req_valid, req_wr, req_addr, req_wdata, input req_ready, rsp_valid, rsp_err, rsp_rdata);
  modport slave(input req_valid, req_wr, req_addr, req_wdata, output req_ready, rsp_valid, rsp_err, rsp_rdata);
endinterface

// File: rtl/usb2_ulpi_reqfifo.sv
// usb2_ulpi_reqfifo: request queue; pushes at full and pops at empty are ignored
module usb2_ulpi_reqfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic phy_clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic empty,
  output logic full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign empty = cnt == '0;
  assign full = cnt == CW'(DEPTH);
  assign dout = mem[rd_ptr];
  // pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage needs no reset: entries are only read once the count covers them
  always_ff @(posedge phy_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/usb2_ulpi_regport.sv
// usb2_ulpi_regport: queued ULPI register read/write engine driving the PHY data bus
module usb2_ulpi_regport
  import usb2_ulpi_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int TIMEOUT = 255,
  parameter int EXT_EN = 1
) (
  input  logic phy_clk,
  input  logic reset,
  usb2_ulpi_regport_if.slave rp,
  output logic bus_req,
  input  logic bus_gnt,
  input  logic phy_dir,
  input  logic phy_nxt,
  input  logic [7:0] phy_d_in,
  output logic [7:0] phy_d_out,
  output logic phy_stp,
  output logic busy
);
  localparam logic [11:0] TO = 12'(TIMEOUT);
  state_t state, state_n, tx_next;
  logic [16:0] head;
  logic empty, full, pop, h_wr, h_ext, unsup, timed, to, abort_q, err_q;
  logic [7:0] h_addr, h_wdata, tx_byte, rdata_q;
  logic [11:0] cnt;
  usb2_ulpi_reqfifo #(.DEPTH(QDEPTH), .WIDTH(17)) u_fifo (
    .phy_clk,
    .reset,
    .push(rp.req_valid),
    .pop,
    .din({rp.req_wr, rp.req_addr, rp.req_wdata}),
    .dout(head),
    .empty,
    .full
  );
  assign {h_wr, h_addr, h_wdata} = head;
  assign h_ext = is_ext(h_addr);
  assign unsup = h_ext && EXT_EN == 0;
  assign timed = state inside {CMD, EADDR, WDATA, TURN, RDATA, WAITDIR};
  assign to = timed && cnt == TO;
  assign tx_byte = state == CMD ? cmd_byte(h_wr, h_addr) : state == EADDR ? h_addr : h_wdata;
  assign tx_next = state == CMD && h_ext ? EADDR : state != WDATA && h_wr ? WDATA : state == WDATA ? STP : TURN;
  // next state and bus byte; aborts and timeouts leave the bus at zero
  always_comb begin
    state_n = state;
    phy_d_out = '0;
    case (state)
      IDLE: if (!empty) state_n = unsup ? DONE : ARB;
      ARB: if (bus_gnt && !phy_dir) state_n = CMD;
      CMD, EADDR, WDATA: begin
        if (to) state_n = DONE;
        else if (phy_dir) state_n = WAITDIR;
        else begin
          phy_d_out = tx_byte;
          if (phy_nxt) state_n = tx_next;
        end
      end
      STP: state_n = DONE;
      TURN: state_n = to ? DONE : phy_dir ? RDATA : TURN;
      RDATA: state_n = WAITDIR;
      WAITDIR: state_n = to ? DONE : phy_dir ? WAITDIR : abort_q ? ARB : DONE;
      default: state_n = IDLE;
    endcase
  end
  // state, per-phase cycle counter, abort marker and response registers
  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      abort_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? '0 : cnt + 12'd1;
      if (state_n == WAITDIR && state != WAITDIR) abort_q <= state != RDATA;
      if (state == IDLE && !empty) begin
        err_q <= unsup;
        rdata_q <= '0;
      end else if (to) begin
        err_q <= 1'b1;
        rdata_q <= '0;
      end else if (state == RDATA) rdata_q <= phy_d_in;
    end
  end
  assign pop = state == DONE;
  assign bus_req = !(state inside {IDLE, DONE});
  assign phy_stp = state == STP;
  assign busy = state != IDLE || !empty;
  assign rp.req_ready = !full;
  assign rp.rsp_valid = state == DONE;
  assign rp.rsp_err = err_q;
  assign rp.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_usb2_ulpi_regport.sv
// tb_usb2_ulpi_regport: directed bench with a transaction-level model of the register port
module tb_usb2_ulpi_regport;
  localparam int QD = 4;
  logic phy_clk = 1'b0;
  logic reset = 1'b1;
  logic bus_req, bus_gnt, phy_dir, phy_nxt, phy_stp, busy;
  logic [7:0] phy_d_in, phy_d_out;
  logic bus_req0, phy_stp0, busy0;
  logic [7:0] phy_d_out0;
  logic zero = 1'b0;
  logic [7:0] zero8 = 8'h00;
  usb2_ulpi_regport_if rif();
  usb2_ulpi_regport_if rif0();
  usb2_ulpi_regport #(.QDEPTH(QD), .TIMEOUT(16), .EXT_EN(1)) u_dut (
    .phy_clk(phy_clk), .reset(reset), .rp(rif), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .phy_dir(phy_dir), .phy_nxt(phy_nxt), .phy_d_in(phy_d_in), .phy_d_out(phy_d_out),
    .phy_stp(phy_stp), .busy(busy)
  );
  usb2_ulpi_regport #(.QDEPTH(QD), .TIMEOUT(16), .EXT_EN(0)) u_dut0 (
    .phy_clk(phy_clk), .reset(reset), .rp(rif0), .bus_req(bus_req0), .bus_gnt(zero),
    .phy_dir(zero), .phy_nxt(zero), .phy_d_in(zero8), .phy_d_out(phy_d_out0),
    .phy_stp(phy_stp0), .busy(busy0)
  );
  always #5 phy_clk = ~phy_clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_rsp = 0;
  int mcount = 0;
  logic [7:0] exp_rd = 8'h00;
  logic exp_to = 1'b0;
  logic m_ext, acc;
  typedef struct packed {logic [7:0] rd; logic err;} rsp_t;
  rsp_t sb[$];
  rsp_t r;
  logic [7:0] bs[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chki(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge phy_clk);
    #1;
  endtask
  task automatic push(input logic wr, input logic [7:0] a, input logic [7:0] d);
    rif.req_valid = 1'b1;
    rif.req_wr = wr;
    rif.req_addr = a;
    rif.req_wdata = d;
    tick();
    rif.req_valid = 1'b0;
  endtask
  task automatic wait_dout(input logic [7:0] b, input string nm);
    int n = 0;
    while (phy_d_out !== b && n < 40) begin
      tick();
      n++;
    end
    chk(nm, phy_d_out, b);
  endtask
  task automatic phase(input logic [7:0] b, input int hold, input string nm);
    wait_dout(b, nm);
    repeat (hold) begin
      tick();
      chk({nm, "_hold"}, phy_d_out, b);
    end
    phy_nxt = 1'b1;
    tick();
    phy_nxt = 1'b0;
  endtask

  // transaction model: queue occupancy, accepted byte stream and expected responses
  always @(negedge phy_clk) begin
    if (reset) begin
      mcount = 0;
      sb.delete();
      bs.delete();
    end else begin
      chk("req_ready", 8'(rif.req_ready), 8'(mcount < QD));
      chk("busy", 8'(busy), 8'(mcount != 0));
      if (phy_stp) chk("stp_dout", phy_d_out, 8'h00);
      if (phy_nxt && !phy_dir && phy_d_out != 8'h00) begin
        if (bs.size() == 0) chk("stream_extra", phy_d_out, 8'h00);
        else chk("stream", phy_d_out, bs.pop_front());
      end
      acc = rif.req_valid && mcount < QD;
      if (rif.rsp_valid) begin
        n_rsp++;
        if (sb.size() == 0) chk("rsp_extra", 8'(rif.rsp_valid), 8'h00);
        else begin
          r = sb.pop_front();
          chk("rsp_rdata", rif.rsp_rdata, r.rd);
          chk("rsp_err", 8'(rif.rsp_err), 8'(r.err));
        end
        mcount--;
      end
      if (acc) begin
        m_ext = rif.req_addr >= 8'h2F;
        sb.push_back('{rd: (rif.req_wr || exp_to) ? 8'h00 : exp_rd, err: exp_to});
        if (!exp_to) begin
          bs.push_back((rif.req_wr ? 8'h80 : 8'hC0) | (m_ext ? 8'h2F : rif.req_addr));
          if (m_ext) bs.push_back(rif.req_addr);
          if (rif.req_wr) bs.push_back(rif.req_wdata);
        end
        mcount++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb;
    logic act;
    bus_gnt = 1'b0;
    phy_dir = 1'b0;
    phy_nxt = 1'b0;
    phy_d_in = 8'h00;
    rif.req_valid = 1'b0; rif.req_wr = 1'b0; rif.req_addr = 8'h00; rif.req_wdata = 8'h00;
    rif0.req_valid = 1'b0; rif0.req_wr = 1'b0; rif0.req_addr = 8'h00; rif0.req_wdata = 8'h00;
    repeat (3) tick();
    chk("rst_dout", phy_d_out, 8'h00);
    chk("rst_stp", 8'(phy_stp), 8'h00);
    chk("rst_bus_req", 8'(bus_req), 8'h00);
    chk("rst_rsp_valid", 8'(rif.rsp_valid), 8'h00);
    chk("rst_rsp_err", 8'(rif.rsp_err), 8'h00);
    chk("rst_rsp_rdata", rif.rsp_rdata, 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_req_ready", 8'(rif.req_ready), 8'h01);
    reset = 1'b0;
    bus_gnt = 1'b1;
    tick();
    // immediate write 0x04 <- 0x45
    push(1'b1, 8'h04, 8'h45);
    phase(8'h84, 2, "wr_cmd");
    phase(8'h45, 2, "wr_data");
    chk("wr_stp", 8'(phy_stp), 8'h01);
    chk("wr_stp_dout", phy_d_out, 8'h00);
    tick();
    chk("wr_stp_end", 8'(phy_stp), 8'h00);
    chk("wr_rsp", 8'(rif.rsp_valid), 8'h01);
    chk("wr_err", 8'(rif.rsp_err), 8'h00);
    repeat (2) tick();
    // extended read 0x3A, PHY returns 0x5C
    exp_rd = 8'h5C;
    push(1'b0, 8'h3A, 8'h00);
    phase(8'hEF, 1, "rd_cmd");
    phase(8'h3A, 1, "rd_eaddr");
    phy_dir = 1'b1;
    #1;
    chk("rd_turn_dout", phy_d_out, 8'h00);
    tick();
    phy_d_in = 8'h5C;
    tick();
    phy_dir = 1'b0;
    phy_d_in = 8'h00;
    tick();
    chk("rd_rsp", 8'(rif.rsp_valid), 8'h01);
    chk("rd_data", rif.rsp_rdata, 8'h5C);
    chk("rd_err", 8'(rif.rsp_err), 8'h00);
    repeat (2) tick();
    // phy_dir rises during CMD: abort and retry
    push(1'b1, 8'h10, 8'h77);
    wait_dout(8'h90, "ab_cmd");
    phy_dir = 1'b1;
    #1;
    chk("ab_dout", phy_d_out, 8'h00);
    repeat (2) begin
      tick();
      chk("ab_wait_dout", phy_d_out, 8'h00);
      chk("ab_wait_bus", 8'(bus_req), 8'h01);
    end
    phy_dir = 1'b0;
    phase(8'h90, 0, "ab_retry_cmd");
    phase(8'h77, 0, "ab_retry_data");
    tick();
    chk("ab_rsp", 8'(rif.rsp_valid), 8'h01);
    repeat (2) tick();
    // nxt never arrives: timeout after 16 cycles in CMD
    exp_to = 1'b1;
    push(1'b1, 8'h05, 8'h11);
    exp_to = 1'b0;
    wait_dout(8'h85, "to_cmd");
    n = 0;
    nb = 0;
    while (!rif.rsp_valid && n < 40) begin
      if (phy_d_out == 8'h85) nb++;
      tick();
      n++;
    end
    chki("to_cycles", n, 17);
    chki("to_bytes", nb, 16);
    chk("to_err", 8'(rif.rsp_err), 8'h01);
    chk("to_rdata", rif.rsp_rdata, 8'h00);
    chk("to_bus_req", 8'(bus_req), 8'h00);
    repeat (2) tick();
    // five pushes into a four-entry queue while the bus is withheld
    bus_gnt = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      push(1'b1, 8'(i), 8'(8'h10 + i));
      if (i == 4) chk("full_ready", 8'(rif.req_ready), 8'h00);
    end
    bus_gnt = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      phase(8'(8'h80 + i), 0, "q_cmd");
      phase(8'(8'h10 + i), 0, "q_data");
    end
    repeat (4) tick();
    chk("q_busy", 8'(busy), 8'h00);
    chki("rsp_total", n_rsp, 8);
    // reset asserted while WDATA is on the bus
    push(1'b1, 8'h06, 8'h99);
    phase(8'h86, 0, "rst_cmd");
    chk("rst_wdata", phy_d_out, 8'h99);
    reset = 1'b1;
    #1;
    chk("mid_rst_stp", 8'(phy_stp), 8'h00);
    chk("mid_rst_dout", phy_d_out, 8'h00);
    chk("mid_rst_busy", 8'(busy), 8'h00);
    chk("mid_rst_ready", 8'(rif.req_ready), 8'h01);
    chk("mid_rst_rsp", 8'(rif.rsp_valid), 8'h00);
    chk("mid_rst_bus_req", 8'(bus_req), 8'h00);
    repeat (2) begin
      tick();
      chk("mid_rst_hold_stp", 8'(phy_stp), 8'h00);
      chk("mid_rst_hold_rsp", 8'(rif.rsp_valid), 8'h00);
    end
    reset = 1'b0;
    repeat (3) tick();
    chk("post_rst_dout", phy_d_out, 8'h00);
    chki("rsp_final", n_rsp, 8);
    // extended address with extended addressing disabled
    rif0.req_valid = 1'b1;
    rif0.req_wr = 1'b0;
    rif0.req_addr = 8'h3A;
    tick();
    rif0.req_valid = 1'b0;
    n = 0;
    act = 1'b0;
    while (!rif0.rsp_valid && n < 10) begin
      act = act | bus_req0 | (phy_d_out0 != 8'h00);
      tick();
      n++;
    end
    chk("ext0_rsp", 8'(rif0.rsp_valid), 8'h01);
    chk("ext0_err", 8'(rif0.rsp_err), 8'h01);
    chk("ext0_rdata", rif0.rsp_rdata, 8'h00);
    chk("ext0_bus", 8'(act | bus_req0), 8'h00);
    repeat (2) tick();
    chk("ext0_busy", 8'(busy0), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/usb2_ulpi_regport.md
USB2_ULPI_REGPORT -- requirements
Module: usb2_ulpi_regport

Interface
REQ-001 Parameter QDEPTH, default 4: request queue depth, power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 255: maximum wait cycles per bus phase, 8..4095.
REQ-003 Parameter EXT_EN, default 1: 1 enables extended (8-bit) register addressing.
REQ-004 phy_clk  in  1  60 MHz ULPI clock; the only clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1 / req_ready  out  1: request push handshake.
REQ-007 req_wr  in  1 (1=write); req_addr  in  8; req_wdata  in  8.
REQ-008 rsp_valid  out  1: one-cycle completion pulse; rsp_rdata  out  8; rsp_err  out  1 (timeout or unsupported address).
REQ-009 bus_req  out  1: bus request to the link FSM; bus_gnt  in  1: link idle, bus granted.
REQ-010 phy_dir  in  1; phy_nxt  in  1; phy_d_in  in  8; phy_d_out  out  8; phy_stp  out  1.
REQ-011 busy  out  1: high when the FSM is not in IDLE or the queue is non-empty.

Function
REQ-012 Requests SHALL enter a QDEPTH-entry FIFO on req_valid&req_ready; req_ready=0 when full; a push at full SHALL be ignored.
REQ-013 The FSM SHALL take states IDLE, ARB, CMD, EADDR, WDATA, STP, TURN, RDATA, WAITDIR, DONE.
REQ-014 IDLE->ARB when the queue is non-empty; ARB asserts bus_req and moves to CMD when bus_gnt=1 and phy_dir=0.
REQ-015 Immediate form: addr<0x2F; cmd byte={wr?2'b10:2'b11, addr[5:0]}. Extended form: addr>=0x2F; cmd byte={op,6'h2F}.
REQ-016 With EXT_EN=0, an extended address SHALL complete in DONE with rsp_err=1 and no bus activity.
REQ-017 CMD, EADDR and WDATA SHALL each hold their byte on phy_d_out until the cycle phy_nxt=1, then advance: CMD->EADDR (extended) / WDATA (write) / TURN (read); EADDR->WDATA or TURN.
REQ-018 STP: after the WDATA nxt, drive phy_stp=1 and phy_d_out=0 for exactly one cycle, then DONE.
REQ-019 Read: TURN waits for phy_dir=1 (turnaround cycle); the next cycle (RDATA) latches phy_d_in into rsp_rdata; WAITDIR waits for phy_dir=0, then DONE.
REQ-020 Abort: phy_dir rising in CMD/EADDR/WDATA before the phase's nxt SHALL drive phy_d_out=0, go to WAITDIR, then ARB, retrying the same request; the head entry SHALL NOT be popped.
REQ-021 A cycle counter SHALL clear on each state change; reaching TIMEOUT SHALL force phy_d_out=0 and transition to DONE with rsp_err=1, rsp_rdata=0.
REQ-022 DONE SHALL pulse rsp_valid for one cycle, pop the head entry, drop bus_req, and return to IDLE; latency from DONE to rsp_valid is 0 cycles (registered output).
REQ-023 phy_d_out SHALL be 0 whenever the FSM is in IDLE, ARB, TURN, RDATA, WAITDIR or DONE.
REQ-024 A push and a pop in the same cycle SHALL leave the count unchanged; a push while empty SHALL be visible to IDLE on the next cycle.

Reset
REQ-025 On reset: FIFO flushed, FSM=IDLE, counter=0; phy_d_out=0, phy_stp=0, bus_req=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, req_ready=1.
REQ-026 Reset mid-transaction SHALL release the bus immediately; no phy_stp pulse and no rsp_valid SHALL be issued.

Structure
REQ-027 Package usb2_ulpi_pkg SHALL hold the ULPI TX_CMD op codes (REGWR=2'b10, REGRD=2'b11), the EXT_ADDR constant 6'h2F, and the FSM state encoding.
REQ-028 The request queue SHALL be a sub-module usb2_ulpi_reqfifo (parameter depth, width 17).

Verification
REQ-029 Immediate write addr 0x04, data 0x45, nxt after 2 cycles -> phy_d_out 0x84 until nxt, then 0x45 until nxt, phy_stp=1 for one cycle, rsp_valid with rsp_err=0.
REQ-030 Extended read addr 0x3A, PHY returns 0x5C -> bytes 0xEF then 0x3A, turnaround, rsp_rdata=0x5C, rsp_err=0.
REQ-031 phy_dir rises in CMD before nxt -> phy_d_out=0, retry after dir falls, exactly one rsp_valid, queue count decremented once.
REQ-032 nxt never asserted, TIMEOUT=16 -> rsp_valid with rsp_err=1 and rsp_rdata=0 after 16 cycles in CMD; bus_req dropped.
REQ-033 Push 5 requests with QDEPTH=4 and bus_gnt=0 -> req_ready=0 after the fourth push, fifth ignored, four responses once granted.
REQ-034 Reset asserted in WDATA -> phy_stp stays 0, phy_d_out=0, busy=0, req_ready=1, no rsp_valid.
